// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl: walks the enabled 8:1 mux channels, dwells, samples and snapshots them.
module mux8_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic [7:0] ch_mask,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic [7:0] sample_vec,
    output logic       done,
    output logic       busy
);
    typedef enum logic {IDLE, SCAN} state_t;
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);
    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [2:0]    nxt_sel;
    logic [7:0]    mask_q, nxt_mask, shadow, nxt_shadow, nxt_vec, cap, hi;
    logic          nxt_done;
    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest = 3'(i);
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 3'd0;
            cnt        <= '0;
            mask_q     <= 8'd0;
            shadow     <= 8'd0;
            sample_vec <= 8'd0;
            done       <= 1'b0;
        end else begin
            state      <= nxt_state;
            sel        <= nxt_sel;
            cnt        <= nxt_cnt;
            mask_q     <= nxt_mask;
            shadow     <= nxt_shadow;
            sample_vec <= nxt_vec;
            done       <= nxt_done;
        end
    end
    always_comb begin
        hi         = mask_q & (8'hFE << sel);
        cap        = (shadow & ~(8'd1 << sel)) | ({7'd0, mux_out} << sel);
        nxt_state  = state;
        nxt_sel    = sel;
        nxt_cnt    = cnt;
        nxt_mask   = mask_q;
        nxt_shadow = shadow;
        nxt_vec    = sample_vec;
        nxt_done   = 1'b0;
        if (state == IDLE) begin
            if (!stop && start && ch_mask != 8'd0) begin
                nxt_state  = SCAN;
                nxt_mask   = ch_mask;
                nxt_shadow = 8'd0;
                nxt_sel    = lowest(ch_mask);
                nxt_cnt    = RELOAD;
            end else if (!stop && start) begin
                nxt_done = 1'b1;
                nxt_vec  = 8'd0;
            end
        end else if (stop) begin
            nxt_state = IDLE;
        end else if (cnt != '0) begin
            nxt_cnt = cnt - 1'b1;
        end else if (hi != 8'd0) begin
            nxt_shadow = cap;
            nxt_sel    = lowest(hi);
            nxt_cnt    = RELOAD;
        end else begin
            // sweep end: publish snapshot, then either rearm from the live mask or retire
            nxt_vec    = cap & mask_q;
            nxt_done   = 1'b1;
            nxt_shadow = cap;
            if (mode && ch_mask != 8'd0) begin
                nxt_mask   = ch_mask;
                nxt_shadow = 8'd0;
                nxt_sel    = lowest(ch_mask);
                nxt_cnt    = RELOAD;
            end else begin
                nxt_state = IDLE;
                if (mode) begin
                    nxt_mask   = ch_mask;
                    nxt_shadow = 8'd0;
                end
            end
        end
    end
    always_comb busy = (state == SCAN);
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb_mux8_scan_ctrl: directed vectors, expected snapshots scoreboarded against done pulses.
module tb_mux8_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] ch_mask = 8'd0;
    logic [7:0] mux_in = 8'd0;
    logic       mux_out;
    logic [2:0] sel;
    logic [7:0] sample_vec;
    logic       done;
    logic       busy;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    typedef struct {
        logic [7:0] vec;
        int         cyc;
    } exp_t;
    exp_t q[$];
    mux8_scan_ctrl #(.DWELL(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .ch_mask(ch_mask), .mux_out(mux_out), .sel(sel),
        .sample_vec(sample_vec), .done(done), .busy(busy)
    );
    assign mux_out = mux_in[sel];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL done_unexpected: got done=1 with empty scoreboard (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sample_vec", int'(sample_vec), int'(e.vec));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic go(input logic [7:0] m, input logic [7:0] ins, input logic md, input logic [7:0] v, input int n);
        mux_in  = ins;
        ch_mask = m;
        mode    = md;
        start   = 1'b1;
        q.push_back('{vec: v, cyc: cyc + 1 + n * 4});
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        chk("idle_timeout", int'(busy), 0);
    endtask
    initial begin
        #2;
        chk("rst_sel", int'(sel), 0);
        chk("rst_vec", int'(sample_vec), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        go(8'hFF, 8'b1010_0110, 1'b0, 8'hA6, 8);
        chk("full_busy", int'(busy), 1);
        chk("full_sel0", int'(sel), 0);
        cycles(4);
        chk("full_sel1", int'(sel), 1);
        cycles(27);
        chk("full_busy_late", int'(busy), 1);
        chk("full_sel7", int'(sel), 7);
        wait_idle();
        cycles(2);
        go(8'h91, 8'hFF, 1'b0, 8'h91, 3);
        chk("sparse_sel0", int'(sel), 0);
        cycles(4);
        chk("sparse_sel4", int'(sel), 4);
        cycles(4);
        chk("sparse_sel7", int'(sel), 7);
        wait_idle();
        cycles(2);
        go(8'h00, 8'hFF, 1'b0, 8'h00, 0);
        chk("zero_busy", int'(busy), 0);
        cycles(3);
        go(8'h03, 8'b0000_1010, 1'b1, 8'h02, 2);
        q.push_back('{vec: 8'h08, cyc: q[0].cyc + 8});
        q.push_back('{vec: 8'h08, cyc: q[0].cyc + 16});
        cycles(3);
        ch_mask = 8'h0C;
        cycles(5);
        chk("cont_sel2", int'(sel), 2);
        chk("cont_busy", int'(busy), 1);
        cycles(12);
        mode = 1'b0;
        wait_idle();
        cycles(2);
        go(8'hFF, 8'h55, 1'b0, 8'h00, 0);
        void'(q.pop_back());
        cycles(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles(1);
        chk("ign_start_sel", int'(sel), 1);
        cycles(3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_vec", int'(sample_vec), 8'h08);
        chk("stop_sel", int'(sel), 1);
        cycles(6);
        go(8'hFF, 8'hFF, 1'b0, 8'h00, 0);
        void'(q.pop_back());
        cycles(10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", int'(sel), 0);
        chk("arst_vec", int'(sample_vec), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        go(8'h81, 8'h80, 1'b0, 8'h80, 2);
        wait_idle();
        cycles(3);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mux8_scan_ctrl.md
Name: mux8_scan_ctrl

Overview:
- Sequencer paired with the 8-to-1 bit mux.
- Drives the mux select and walks the enabled channels in ascending order.
- Holds each select for a settle/dwell window, then samples the mux output bit.
- Assembles the sampled bits into an 8-bit snapshot vector for downstream logic; supports single-sweep and continuous scanning.

Parameters:
- DWELL, 4: cycles each select is held before mux_out is sampled; legal range 1..255.
- CW, 8: width of the internal dwell counter; must hold DWELL-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; ignored while busy=1.
- stop  input  1  abort the scan and return to IDLE.
- mode  input  1  0 = single sweep, 1 = continuous sweeps.
- ch_mask  input  8  channel enable mask; bit k enables mux input k.
- mux_out  input  1  output bit of the 8-to-1 mux.
- sel  output  3  drives the mux select.
- sample_vec  output  8  last completed sweep snapshot; bit k holds the channel k sample.
- done  output  1  one-cycle pulse at the end of each completed sweep.
- busy  output  1  high while the block is in the SCAN state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=0, sample_vec=0, done=0, busy=0, shadow=0, cnt=0, mask_q=0. All registers update on rising clk edges only after reset is released.
- States are IDLE and SCAN. busy=1 exactly when state=SCAN.
- IDLE, start=1, stop=0, ch_mask!=0:
  - mask_q<=ch_mask; shadow<=0.
  - sel<=lowest set bit of ch_mask; cnt<=DWELL-1; state->SCAN.
- IDLE, start=1, ch_mask==0: stay in IDLE; done=1 for the next cycle; sample_vec<=0.
- IDLE, stop=1: stay in IDLE; stop has priority over a simultaneous start.
- SCAN, cnt!=0: cnt<=cnt-1; sel held.
- SCAN, cnt==0 (capture edge): shadow[sel]<=mux_out. Then:
  - If mask_q has a set bit above sel: sel<=that lowest higher bit; cnt<=DWELL-1.
  - Otherwise the sweep ends. On the same edge, sample_vec<=shadow with bit sel replaced by mux_out, and bits where mask_q=0 forced to 0. done=1 for the following cycle.
- Sweep end, mode=0: state->IDLE. sel holds its last value.
- Sweep end, mode=1:
  - mask_q<=ch_mask, re-latched at the sweep boundary; shadow<=0.
  - If the new mask is nonzero: sel<=its lowest set bit; cnt<=DWELL-1; stay in SCAN.
  - If the new mask is zero: state->IDLE.
- mode is sampled only at the sweep-end edge.
- ch_mask changes mid-sweep have no effect until the next latch point.
- SCAN, stop=1 at any edge:
  - state->IDLE; no capture; no done.
  - sample_vec keeps its previous snapshot; sel holds.
  - stop wins over a coincident capture or sweep end.
- start=1 while in SCAN is ignored.
- Timing, with start accepted at edge E0 and N enabled channels:
  - Channel i (0-based order) is sampled at edge E0+(i+1)*DWELL.
  - sample_vec updates at edge E0+N*DWELL; done is high in the cycle after that edge.
  - Continuous mode adds no gap cycles between sweeps.
- With DWELL=1, each enabled channel takes exactly one cycle.
- mux_out must be stable one cycle after each sel change. DWELL>=2 is recommended when the mux is registered.
- Reset asserted mid-scan clears all state immediately and asynchronously. No done is issued.

Test Plan:
- Single sweep, DWELL=4, ch_mask=8'hFF, mux inputs = 8'b1010_0110: sel steps 0..7, each held 4 cycles -> sample_vec=8'hA6 at E0+32; done pulses once; busy falls with done.
- Sparse mask 8'h91, inputs = 8'hFF: sel visits 0, 4, 7 only -> sample_vec=8'h91 at E0+12; masked bits read 0.
- ch_mask=0 with start -> busy stays 0; done pulses for 1 cycle; sample_vec=0.
- Continuous mode, mask 8'h03, mid-run ch_mask changes to 8'h0C:
  - Current sweep finishes on channels 0 and 1.
  - Next sweep visits channels 2 and 3; done is pulsed every 8 cycles.
- stop asserted on a capture edge of the second channel -> IDLE next cycle; no done; sample_vec unchanged; a start pulse during SCAN is ignored.
- rst_n pulled low mid-scan -> sel, sample_vec, done and busy go to 0 immediately; after release, start behaves normally.
